// File: rtl/img_mem_arbiter.sv
// img_mem_arbiter: shares one RAM read port between N_REQ address requesters.
// Round-robin grant, credit-limited issue, a fixed-latency tag pipe that follows
// each read through the RAM, and an in-order tagged response FIFO.
module img_mem_arbiter #(
   parameter int N_REQ       = 2,
   parameter int W_ADDR      = 11,
   parameter int W_DATA      = 8,
   parameter int MEM_LATENCY = 1,
   parameter int RSP_DEPTH   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*W_ADDR-1:0]   req_addr,
   output logic                      mem_en,
   output logic [W_ADDR-1:0]         mem_addr,
   input  logic [W_DATA-1:0]         mem_rdata,
   output logic [N_REQ-1:0]          rsp_valid,
   input  logic [N_REQ-1:0]          rsp_ready,
   output logic [W_DATA-1:0]         rsp_data
);

   localparam int W_TAG = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int W_FP  = $clog2(RSP_DEPTH);
   localparam int W_CRD = $clog2(RSP_DEPTH + 1);

   localparam logic [W_CRD-1:0] CRD_MAX = W_CRD'(RSP_DEPTH);
   localparam logic [W_TAG-1:0] PTR_RST = W_TAG'(N_REQ - 1);

   // Round-robin pointer: index of the most recently granted requester.
   logic [W_TAG-1:0]       ptr_q, ptr_d;
   // Reads in flight plus FIFO occupancy.
   logic [W_CRD-1:0]       credit_q, credit_d;
   // Tag pipe, one stage per cycle of RAM latency.
   logic [MEM_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
   logic [W_TAG-1:0]       pipe_tag_q [MEM_LATENCY];
   logic [W_TAG-1:0]       pipe_tag_d [MEM_LATENCY];
   // Response FIFO; pointers carry one extra wrap bit.
   logic [W_FP:0]          wr_ptr_q, wr_ptr_d;
   logic [W_FP:0]          rd_ptr_q, rd_ptr_d;
   logic [W_TAG-1:0]       fifo_tag_q  [RSP_DEPTH];
   logic [W_DATA-1:0]      fifo_data_q [RSP_DEPTH];

   logic                   win_found;
   logic [W_TAG-1:0]       win_idx;
   logic                   issue;
   logic                   push;
   logic                   pop;
   logic                   fifo_empty;
   logic [W_TAG-1:0]       head_tag;
   logic [W_DATA-1:0]      head_data;

   // Round-robin search starting one past the last winner, with wrap.
   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!win_found && req_valid[(int'(ptr_q) + k) % N_REQ]) begin
            win_found = 1'b1;
            win_idx   = W_TAG'((int'(ptr_q) + k) % N_REQ);
         end
      end
   end

   // FIFO head presents to its own requester; only that requester's rsp_ready pops it.
   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      head_tag   = fifo_tag_q[rd_ptr_q[W_FP-1:0]];
      head_data  = fifo_data_q[rd_ptr_q[W_FP-1:0]];
      rsp_valid  = '0;
      rsp_data   = '0;
      if (!fifo_empty) begin
         rsp_valid[head_tag] = 1'b1;
         rsp_data            = head_data;
      end
      pop = !fifo_empty && rsp_ready[head_tag];
   end

   // Grant, RAM drive, pointer and credit update.
   // A slot freed by a pop in this cycle may be reused by an issue in the same
   // cycle; the credit then stays put and the FIFO still cannot overflow, because
   // the new read lands MEM_LATENCY cycles after the popped entry has left.
   always_comb begin
      issue     = win_found && !rst && ((credit_q < CRD_MAX) || pop);
      req_ready = '0;
      mem_en    = issue;
      mem_addr  = '0;
      ptr_d     = ptr_q;
      credit_d  = credit_q;
      if (issue) begin
         req_ready[win_idx] = 1'b1;
         mem_addr           = req_addr[int'(win_idx)*W_ADDR +: W_ADDR];
         ptr_d              = win_idx;
      end
      if (issue && !pop) begin
         credit_d = credit_q + W_CRD'(1);
      end else if (!issue && pop) begin
         credit_d = credit_q - W_CRD'(1);
      end
   end

   // Tag pipe shift and FIFO pointer advance.
   always_comb begin
      pipe_vld_d    = '0;
      pipe_tag_d    = '{default: '0};
      pipe_vld_d[0] = issue;
      pipe_tag_d[0] = win_idx;
      for (int s = 1; s < MEM_LATENCY; s++) begin
         pipe_vld_d[s] = pipe_vld_q[s-1];
         pipe_tag_d[s] = pipe_tag_q[s-1];
      end
      push     = pipe_vld_q[MEM_LATENCY-1];
      wr_ptr_d = wr_ptr_q + (W_FP+1)'(push);
      rd_ptr_d = rd_ptr_q + (W_FP+1)'(pop);
   end

   // Control state; reset drops in-flight tags so late RAM data is never pushed.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= PTR_RST;
         credit_q   <= '0;
         pipe_vld_q <= '0;
         pipe_tag_q <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         ptr_q      <= ptr_d;
         credit_q   <= credit_d;
         pipe_vld_q <= pipe_vld_d;
         pipe_tag_q <= pipe_tag_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Response storage written when the tag pipe delivers a completed read.
   // NOTE: storage array is not reset; empty pointers make its contents invisible.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_tag_q[wr_ptr_q[W_FP-1:0]]  <= pipe_tag_q[MEM_LATENCY-1];
         fifo_data_q[wr_ptr_q[W_FP-1:0]] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_img_mem_arbiter.sv
// tb_img_mem_arbiter: directed bench for img_mem_arbiter with N_REQ=2,
// MEM_LATENCY=1, RSP_DEPTH=4 and a RAM model holding RAM[a]=a.
module tb_img_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [21:0] req_addr = '0;
   logic        mem_en;
   logic [10:0] mem_addr;
   logic [7:0]  mem_rdata = '0;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready = '0;
   logic [7:0]  rsp_data;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   img_mem_arbiter #(
      .N_REQ(2), .W_ADDR(11), .W_DATA(8), .MEM_LATENCY(1), .RSP_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
   );

   always #5 clk = ~clk;

   // One-cycle-latency RAM holding RAM[a] = a.
   always @(posedge clk) begin
      if (mem_en) mem_rdata <= mem_addr[7:0];
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Check every output in the current cycle, 2 time units after the edge.
   task automatic cyc(input string tag, input logic [1:0] rr, input logic en,
                      input int addr, input logic [1:0] rv, input int rd);
      #1;
      chk({tag, ".req_ready"}, 32'(req_ready), 32'(rr));
      chk({tag, ".mem_en"},    32'(mem_en),    32'(en));
      chk({tag, ".mem_addr"},  32'(mem_addr),  addr);
      chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(rv));
      chk({tag, ".rsp_data"},  32'(rsp_data),  rd);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] v, input int a0, input int a1);
      req_valid = v;
      req_addr  = {11'(a1), 11'(a0)};
   endtask

   task automatic do_reset();
      set_req(2'b00, 0, 0);
      rsp_ready = 2'b00;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // Reset state: outputs held at zero even with requests present.
      set_req(2'b11, 3, 4);
      #1 rst = 1'b1;
      cyc("rst_async", 2'b00, 1'b0, 0, 2'b00, 0);
      tick();
      tick();
      cyc("rst_held", 2'b00, 1'b0, 0, 2'b00, 0);
      set_req(2'b00, 0, 0);
      rst = 1'b0;

      // 1: req0 alone, back-to-back addresses 5..8.
      rsp_ready = 2'b01;
      set_req(2'b01, 5, 0); cyc("t1c0", 2'b01, 1'b1, 5, 2'b00, 0); tick();
      set_req(2'b01, 6, 0); cyc("t1c1", 2'b01, 1'b1, 6, 2'b00, 0); tick();
      set_req(2'b01, 7, 0); cyc("t1c2", 2'b01, 1'b1, 7, 2'b01, 5); tick();
      set_req(2'b01, 8, 0); cyc("t1c3", 2'b01, 1'b1, 8, 2'b01, 6); tick();
      set_req(2'b00, 0, 0); cyc("t1c4", 2'b00, 1'b0, 0, 2'b01, 7); tick();
      cyc("t1c5", 2'b00, 1'b0, 0, 2'b01, 8); tick();
      cyc("t1c6", 2'b00, 1'b0, 0, 2'b00, 0);

      // 2: both hold valid; grants alternate starting at req0.
      do_reset();
      rsp_ready = 2'b11;
      set_req(2'b11, 10, 20); cyc("t2c0", 2'b01, 1'b1, 10, 2'b00, 0);  tick();
      set_req(2'b11, 11, 20); cyc("t2c1", 2'b10, 1'b1, 20, 2'b00, 0);  tick();
      set_req(2'b11, 11, 21); cyc("t2c2", 2'b01, 1'b1, 11, 2'b01, 10); tick();
      set_req(2'b10, 0, 21);  cyc("t2c3", 2'b10, 1'b1, 21, 2'b10, 20); tick();
      set_req(2'b00, 0, 0);   cyc("t2c4", 2'b00, 1'b0, 0, 2'b01, 11);  tick();
      cyc("t2c5", 2'b00, 1'b0, 0, 2'b10, 21); tick();
      cyc("t2c6", 2'b00, 1'b0, 0, 2'b00, 0);

      // 3: credit limit with responses stalled; pop frees one issue in the same cycle.
      rsp_ready = 2'b00;
      set_req(2'b01, 30, 0); cyc("t3c0", 2'b01, 1'b1, 30, 2'b00, 0);  tick();
      set_req(2'b01, 31, 0); cyc("t3c1", 2'b01, 1'b1, 31, 2'b00, 0);  tick();
      set_req(2'b01, 32, 0); cyc("t3c2", 2'b01, 1'b1, 32, 2'b01, 30); tick();
      set_req(2'b01, 33, 0); cyc("t3c3", 2'b01, 1'b1, 33, 2'b01, 30); tick();
      set_req(2'b01, 34, 0); cyc("t3c4", 2'b00, 1'b0, 0, 2'b01, 30);  tick();
      cyc("t3c5", 2'b00, 1'b0, 0, 2'b01, 30); tick();
      rsp_ready = 2'b01;
      cyc("t3pop", 2'b01, 1'b1, 34, 2'b01, 30); tick();
      rsp_ready = 2'b00;
      set_req(2'b01, 35, 0); cyc("t3full", 2'b00, 1'b0, 0, 2'b01, 31); tick();
      set_req(2'b00, 0, 0);
      rsp_ready = 2'b01;
      for (int i = 31; i <= 34; i++) begin
         cyc($sformatf("t3drain%0d", i), 2'b00, 1'b0, 0, 2'b01, i);
         tick();
      end
      cyc("t3empty", 2'b00, 1'b0, 0, 2'b00, 0);

      // 4: head tagged 1 and stalled blocks req0 data queued behind it.
      rsp_ready = 2'b01;
      set_req(2'b11, 40, 50); cyc("t4c0", 2'b10, 1'b1, 50, 2'b00, 0); tick();
      set_req(2'b01, 40, 0);  cyc("t4c1", 2'b01, 1'b1, 40, 2'b00, 0); tick();
      set_req(2'b00, 0, 0);   cyc("t4c2", 2'b00, 1'b0, 0, 2'b10, 50); tick();
      cyc("t4c3", 2'b00, 1'b0, 0, 2'b10, 50); tick();
      cyc("t4c4", 2'b00, 1'b0, 0, 2'b10, 50); tick();
      rsp_ready = 2'b11;
      cyc("t4pop1", 2'b00, 1'b0, 0, 2'b10, 50); tick();
      cyc("t4rsp0", 2'b00, 1'b0, 0, 2'b01, 40); tick();
      cyc("t4done", 2'b00, 1'b0, 0, 2'b00, 0);

      // 5: reset mid-burst with reads outstanding.
      rsp_ready = 2'b00;
      set_req(2'b01, 60, 0);  cyc("t5c0", 2'b01, 1'b1, 60, 2'b00, 0);  tick();
      set_req(2'b01, 61, 0);  cyc("t5c1", 2'b01, 1'b1, 61, 2'b00, 0);  tick();
      set_req(2'b01, 62, 0);  cyc("t5c2", 2'b01, 1'b1, 62, 2'b01, 60); tick();
      set_req(2'b11, 63, 70); cyc("t5c3", 2'b10, 1'b1, 70, 2'b01, 60);
      rst = 1'b1;
      cyc("t5async", 2'b00, 1'b0, 0, 2'b00, 0);
      tick();
      tick();
      rsp_ready = 2'b11;
      rst = 1'b0;
      cyc("t5rel", 2'b01, 1'b1, 63, 2'b00, 0); tick();
      set_req(2'b10, 0, 70); cyc("t5stale", 2'b10, 1'b1, 70, 2'b00, 0); tick();
      set_req(2'b00, 0, 0);  cyc("t5rsp0", 2'b00, 1'b0, 0, 2'b01, 63); tick();
      cyc("t5rsp1", 2'b00, 1'b0, 0, 2'b10, 70); tick();
      cyc("t5done", 2'b00, 1'b0, 0, 2'b00, 0);

      // 6: req1 alone after reset, then req0 wins the next contention.
      do_reset();
      rsp_ready = 2'b11;
      set_req(2'b10, 0, 80);  cyc("t6c0", 2'b10, 1'b1, 80, 2'b00, 0); tick();
      set_req(2'b11, 90, 81); cyc("t6c1", 2'b01, 1'b1, 90, 2'b00, 0); tick();
      set_req(2'b00, 0, 0);   cyc("t6c2", 2'b00, 1'b0, 0, 2'b10, 80); tick();
      cyc("t6c3", 2'b00, 1'b0, 0, 2'b01, 90); tick();
      cyc("t6c4", 2'b00, 1'b0, 0, 2'b00, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
